led_adc_scheduler: RTL
======================

// Module: led_adc_scheduler
// PURPOSE
//  Runtime sequencer for the pulse-oximeter front end once calibration has finished.
//  Time-multiplexes the RED and IR LEDs and applies each channel's stored DC_Comp/PGA_Gain.
//  Waits for analog settling, averages ADC samples per phase and publishes one RED/IR pair per frame.
//  Sits between the calibration controller (source of per-channel settings) and the AFE/ADC pins.
// PARAMETERS
//  SETTLE_CYC  16  cycles after an LED/gain change before sampling starts (>=1)
//  AVG_LOG2    2   log2 of samples averaged per phase (N = 2**AVG_LOG2, 0..4)
//  DARK_CYC    32  cycles with both LEDs off at end of frame (>=1)
// PORTS
//  CLK            in   1  system clock
//  rst            in   1  asynchronous reset, active-high
//  enable         in   1  run scheduler (driven by calibration-complete flag)
//  ADC            in   8  ADC code, sampled on CLK
//  RED_DC_Comp    in   7  calibrated DC compensation, RED
//  IR_DC_Comp     in   7  calibrated DC compensation, IR
//  RED_PGA        in   4  calibrated PGA gain, RED
//  IR_PGA         in   4  calibrated PGA gain, IR
//  LED_RED        out  1  RED LED on
//  LED_IR         out  1  IR LED on
//  DC_Comp        out  7  DC compensation applied to AFE
//  PGA_Gain       out  4  PGA gain applied to AFE
//  RED_ADC_Value  out  8  averaged RED sample, held until next frame
//  IR_ADC_Value   out  8  averaged IR sample, held until next frame
//  sample_valid   out  1  1-cycle pulse: both values updated this frame
//  clip           out  1  sticky-per-frame: some sample in frame was 0 or 255
// BEHAVIOUR
//  Reset: state IDLE; LED_RED=LED_IR=0, DC_Comp=7'd64, PGA_Gain=0, both values=0, sample_valid=0, clip=0.
//  States: IDLE -> RED_SETTLE -> RED_ACQ -> IR_SETTLE -> IR_ACQ -> DARK -> RED_SETTLE ...
//  IDLE: LEDs off; on enable=1 latch all four config inputs into shadow regs, go RED_SETTLE.
//  Config shadow also reloads at every DARK->RED_SETTLE; mid-frame input changes ignored.
//  RED_SETTLE: LED_RED=1, DC_Comp/PGA_Gain=RED shadow; counter runs SETTLE_CYC cycles, then RED_ACQ.
//  RED_ACQ: accumulate ADC for exactly N cycles into (8+AVG_LOG2)-bit acc, no overflow possible;
//   result = acc >> AVG_LOG2 (truncate), stored in internal red_tmp; go IR_SETTLE.
//  IR_SETTLE/IR_ACQ: same with LED_IR=1 and IR shadow; LED_RED=0 (never both LEDs on).
//  On IR_ACQ completion: RED_ADC_Value<=red_tmp, IR_ADC_Value<=IR avg, sample_valid=1 for that
//   single cycle, clip<=frame clip accumulator; go DARK.
//  DARK: LEDs off, outputs keep IR settings; DARK_CYC cycles, then RED_SETTLE.
//  Outputs are registered: LED/DC/PGA change on the clock edge that enters the state.
//  Frame length = 2*(SETTLE_CYC+N) + DARK_CYC cycles; first sample_valid that many minus
//   DARK_CYC cycles after the enable edge that leaves IDLE.
//  enable=0 in any state: next cycle -> IDLE, LEDs off, acc/counters cleared, no sample_valid,
//   RED/IR values and clip retain last published frame.
//  enable re-asserted: fresh frame from RED_SETTLE with newly latched config.
//  rst asserted mid-frame: immediate return to reset values regardless of enable.
//  Frame clip accumulator cleared at RED_SETTLE entry; any ACQ sample of 8'd0 or 8'd255 sets it.
// STRUCTURE
//  Shared package: state encoding (one-hot, localparams ST_IDLE..ST_DARK), DC_COMP_RESET=7'd64,
//   ADC_MIN=8'd0, ADC_MAX=8'd255.
//  Sub-module: sample_averager (clear, en, ADC in, done after N samples, 8-bit avg out),
//   instantiated once and reused for both channels.
//  Single down-counter shared by SETTLE/ACQ/DARK phases.
// TESTING
//  Defaults, enable rises, ADC const 100 -> sample_valid after 40 cycles, RED=IR=100, clip=0.
//  ADC=120 in RED_ACQ, 200 in IR_ACQ; RED cfg 30/5, IR cfg 90/9 -> RED=120, IR=200;
//   DC_Comp/PGA_Gain = 30/5 while LED_RED, 90/9 while LED_IR; LEDs never both 1.
//  ADC 10,11,12,13 in RED_ACQ -> RED_ADC_Value=11 (46>>2, truncate).
//  One ADC=255 sample in IR_ACQ -> clip=1 that frame; next clean frame -> clip=0.
//  Drop enable in IR_ACQ -> LEDs off next cycle, no pulse, previous values held; re-enable
//   -> next valid exactly 40 cycles later.
//  Change RED_DC_Comp mid-frame -> DC_Comp unchanged until next RED_SETTLE; rst pulse -> all reset values.

Source files
------------

// File: rtl/led_adc_scheduler_pkg.sv
// rtl/led_adc_scheduler_pkg.sv - shared state encoding and constants for the LED/ADC scheduler
// Purpose: one-hot phase encoding, AFE reset value, ADC rail codes and a rail-detect helper.
// Ports: none (package).
package led_adc_scheduler_pkg;

    localparam logic [5:0] ST_IDLE       = 6'b000001;
    localparam logic [5:0] ST_RED_SETTLE = 6'b000010;
    localparam logic [5:0] ST_RED_ACQ    = 6'b000100;
    localparam logic [5:0] ST_IR_SETTLE  = 6'b001000;
    localparam logic [5:0] ST_IR_ACQ     = 6'b010000;
    localparam logic [5:0] ST_DARK       = 6'b100000;

    typedef enum logic [5:0] {
        S_IDLE       = ST_IDLE,
        S_RED_SETTLE = ST_RED_SETTLE,
        S_RED_ACQ    = ST_RED_ACQ,
        S_IR_SETTLE  = ST_IR_SETTLE,
        S_IR_ACQ     = ST_IR_ACQ,
        S_DARK       = ST_DARK
    } state_t;

    localparam logic [6:0] DC_COMP_RESET = 7'd64;
    localparam logic [7:0] ADC_MIN       = 8'd0;
    localparam logic [7:0] ADC_MAX       = 8'd255;

    // A sample sitting on either ADC rail means the front end is saturated.
    function automatic logic is_clip(input logic [7:0] sample);
        return (sample == ADC_MIN) || (sample == ADC_MAX);
    endfunction

endpackage

// File: rtl/led_adc_scheduler_sample_averager.sv
// rtl/led_adc_scheduler_sample_averager.sv - boxcar averager of 2**AVG_LOG2 ADC samples
// Purpose: accumulates one sample per enabled cycle; on the Nth sample raises done with the
//          truncated mean (including that sample) and restarts empty for the next channel.
// Ports: clk/rst clock and async active-high reset; clear drops any partial sum;
//        en accepts adc this cycle; done marks the final sample; avg is the 8-bit mean.
module sample_averager #(
    parameter int AVG_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] adc,
    output logic       done,
    output logic [7:0] avg
);
    localparam int N  = 1 << AVG_LOG2;
    localparam int AW = 8 + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [AW-1:0] acc_q, acc_d, sum;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // N*255 < 2**(8+AVG_LOG2), so the sum can never wrap.
        sum   = acc_q + AW'(adc);
        done  = en && (cnt_q == CW'(N - 1));
        avg   = sum[AW-1:AVG_LOG2];
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (en) begin
            if (done) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_adc_scheduler.sv
// rtl/led_adc_scheduler.sv - runtime RED/IR LED sequencer with per-phase ADC averaging
// Purpose: cycles RED settle/acquire, IR settle/acquire and a dark gap, driving the AFE with
//          each channel's shadowed calibration and publishing one averaged RED/IR pair per frame.
// Ports: CLK, rst (async active-high); enable runs the sequencer; ADC sample input;
//        RED_/IR_DC_Comp, RED_/IR_PGA calibrated settings; LED_RED/LED_IR, DC_Comp, PGA_Gain
//        to the AFE; RED_/IR_ADC_Value averaged results; sample_valid per-frame strobe;
//        clip set when any acquired sample in the frame hit a rail.
module led_adc_scheduler
    import led_adc_scheduler_pkg::*;
#(
    parameter int SETTLE_CYC = 16,
    parameter int AVG_LOG2   = 2,
    parameter int DARK_CYC   = 32
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] ADC,
    input  logic [6:0] RED_DC_Comp,
    input  logic [6:0] IR_DC_Comp,
    input  logic [3:0] RED_PGA,
    input  logic [3:0] IR_PGA,
    output logic       LED_RED,
    output logic       LED_IR,
    output logic [6:0] DC_Comp,
    output logic [3:0] PGA_Gain,
    output logic [7:0] RED_ADC_Value,
    output logic [7:0] IR_ADC_Value,
    output logic       sample_valid,
    output logic       clip
);
    localparam int          N           = 1 << AVG_LOG2;
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] ACQ_LOAD    = 16'(N - 1);
    localparam logic [15:0] DARK_LOAD   = 16'(DARK_CYC - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [6:0]  red_dc_sh_q, red_dc_sh_d, ir_dc_sh_q, ir_dc_sh_d;
    logic [3:0]  red_pga_sh_q, red_pga_sh_d, ir_pga_sh_q, ir_pga_sh_d;
    logic        led_red_q, led_red_d, led_ir_q, led_ir_d;
    logic [6:0]  dc_q, dc_d;
    logic [3:0]  pga_q, pga_d;
    logic [7:0]  red_tmp_q, red_tmp_d;
    logic [7:0]  red_val_q, red_val_d, ir_val_q, ir_val_d;
    logic        sv_q, sv_d;
    logic        clip_q, clip_d, clip_acc_q, clip_acc_d;

    logic        acq, avg_clear, avg_en, avg_done, sample_clip, start_frame;
    logic [7:0]  avg;

    assign acq         = (state_q == S_RED_ACQ) || (state_q == S_IR_ACQ);
    assign avg_clear   = !enable || (state_q == S_IDLE);
    assign avg_en      = enable && acq;
    assign sample_clip = avg_en && is_clip(ADC);

    sample_averager #(.AVG_LOG2(AVG_LOG2)) u_avg (
        .clk   (CLK),
        .rst   (rst),
        .clear (avg_clear),
        .en    (avg_en),
        .adc   (ADC),
        .done  (avg_done),
        .avg   (avg)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        red_dc_sh_d  = red_dc_sh_q;
        ir_dc_sh_d   = ir_dc_sh_q;
        red_pga_sh_d = red_pga_sh_q;
        ir_pga_sh_d  = ir_pga_sh_q;
        led_red_d    = led_red_q;
        led_ir_d     = led_ir_q;
        dc_d         = dc_q;
        pga_d        = pga_q;
        red_tmp_d    = red_tmp_q;
        red_val_d    = red_val_q;
        ir_val_d     = ir_val_q;
        sv_d         = 1'b0;
        clip_d       = clip_q;
        clip_acc_d   = clip_acc_q;
        start_frame  = 1'b0;

        if (!enable) begin
            // Published values and clip stay as the last complete frame left them.
            state_d    = S_IDLE;
            cnt_d      = '0;
            led_red_d  = 1'b0;
            led_ir_d   = 1'b0;
            clip_acc_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: start_frame = 1'b1;
                S_RED_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = S_RED_ACQ;
                        cnt_d   = ACQ_LOAD;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                S_RED_ACQ: begin
                    clip_acc_d = clip_acc_q | sample_clip;
                    if (avg_done) red_tmp_d = avg;
                    if (cnt_q == '0) begin
                        state_d   = S_IR_SETTLE;
                        cnt_d     = SETTLE_LOAD;
                        led_red_d = 1'b0;
                        led_ir_d  = 1'b1;
                        dc_d      = ir_dc_sh_q;
                        pga_d     = ir_pga_sh_q;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                S_IR_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = S_IR_ACQ;
                        cnt_d   = ACQ_LOAD;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                S_IR_ACQ: begin
                    clip_acc_d = clip_acc_q | sample_clip;
                    if (avg_done) begin
                        red_val_d = red_tmp_q;
                        ir_val_d  = avg;
                        sv_d      = 1'b1;
                        clip_d    = clip_acc_q | sample_clip;
                    end
                    if (cnt_q == '0) begin
                        // DC_Comp/PGA_Gain deliberately keep the IR settings through DARK.
                        state_d  = S_DARK;
                        cnt_d    = DARK_LOAD;
                        led_ir_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                S_DARK: begin
                    if (cnt_q == '0) start_frame = 1'b1;
                    else             cnt_d = cnt_q - 16'd1;
                end
                default: state_d = S_IDLE;
            endcase

            // Frame start: shadow the live config and drive it straight to the AFE on the same edge.
            if (start_frame) begin
                red_dc_sh_d  = RED_DC_Comp;
                ir_dc_sh_d   = IR_DC_Comp;
                red_pga_sh_d = RED_PGA;
                ir_pga_sh_d  = IR_PGA;
                state_d      = S_RED_SETTLE;
                cnt_d        = SETTLE_LOAD;
                led_red_d    = 1'b1;
                led_ir_d     = 1'b0;
                dc_d         = RED_DC_Comp;
                pga_d        = RED_PGA;
                clip_acc_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            red_dc_sh_q  <= DC_COMP_RESET;
            ir_dc_sh_q   <= DC_COMP_RESET;
            red_pga_sh_q <= '0;
            ir_pga_sh_q  <= '0;
            led_red_q    <= 1'b0;
            led_ir_q     <= 1'b0;
            dc_q         <= DC_COMP_RESET;
            pga_q        <= '0;
            red_tmp_q    <= '0;
            red_val_q    <= '0;
            ir_val_q     <= '0;
            sv_q         <= 1'b0;
            clip_q       <= 1'b0;
            clip_acc_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            red_dc_sh_q  <= red_dc_sh_d;
            ir_dc_sh_q   <= ir_dc_sh_d;
            red_pga_sh_q <= red_pga_sh_d;
            ir_pga_sh_q  <= ir_pga_sh_d;
            led_red_q    <= led_red_d;
            led_ir_q     <= led_ir_d;
            dc_q         <= dc_d;
            pga_q        <= pga_d;
            red_tmp_q    <= red_tmp_d;
            red_val_q    <= red_val_d;
            ir_val_q     <= ir_val_d;
            sv_q         <= sv_d;
            clip_q       <= clip_d;
            clip_acc_q   <= clip_acc_d;
        end
    end

    assign LED_RED       = led_red_q;
    assign LED_IR        = led_ir_q;
    assign DC_Comp       = dc_q;
    assign PGA_Gain      = pga_q;
    assign RED_ADC_Value = red_val_q;
    assign IR_ADC_Value  = ir_val_q;
    assign sample_valid  = sv_q;
    assign clip          = clip_q;

endmodule
